hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  EX-stage consumer of the 8-bit alucontrol code produced by the ALU decoder.
//  Executes the HI/LO class of ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
//  Owns the HI/LO register pair; MFHI/MFLO read it through hi_o/lo_o.
//  Uses a radix-2 restoring divider. Stalls the pipeline while a divide runs.
// PARAMETERS
//  DATA_W   32   operand width; HI, LO, quotient and remainder are all DATA_W bits
// PORTS
//  clk          in   1        single clock; all state updates on posedge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        EX-stage instruction valid this cycle
//  flush        in   1        exception/flush; aborts any in-flight op
//  alucontrol   in   8        op code (`EXE_*_OP macros from defines.vh)
//  a            in   DATA_W   rs value (dividend / multiplicand / MTHI-MTLO source)
//  b            in   DATA_W   rt value (divisor / multiplier)
//  stall        out  1        holds IF..EX stages while a divide is pending
//  busy         out  1        FSM is not in IDLE
//  done         out  1        1-cycle pulse; divide result is written this edge
//  hi_o         out  DATA_W   current HI register
//  lo_o         out  DATA_W   current LO register
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, HI=LO=0, count=0; stall=busy=done=0.
//  Accept condition: an op is accepted only when start=1, flush=0 and state=IDLE.
//    With start=1 in any other state, the op is ignored.
//  MULT / MULTU: full 2*DATA_W product, signed or unsigned.
//    {HI,LO} <= product at the accepting edge. No stall.
//  MTHI / MTLO: HI <= a or LO <= a at the accepting edge. No stall.
//  Any other code, including MFHI/MFLO: no state change.
//  DIV / DIVU on accept with b != 0:
//    stall=1 combinationally in the accept cycle.
//    Latch |a| and |b| (signed only) and the two sign bits.
//    count<=0; state IDLE->DIVIDE.
//  DIVIDE: one restoring step per cycle.
//    Shift {rem,quo} left by one; trial-subtract the divisor.
//    If the result is non-negative, keep it and set quotient bit 0.
//    count++. After DATA_W steps (count==DATA_W-1) go to FINISH.
//    stall=busy=1 throughout.
//  FINISH: stall=0, busy=1, done=1.
//    Signed sign-fix: quotient is negated if the operand signs differ.
//    Signed sign-fix: remainder takes the sign of the dividend.
//    LO<=quotient, HI<=remainder at this edge; then go to IDLE.
//  Latency: accept edge + DATA_W DIVIDE cycles + 1 FINISH cycle.
//    stall is high for DATA_W+1 cycles (33 at default).
//  Divide by zero (b==0): completes through FINISH in 1 cycle with no DIVIDE state.
//    LO<=all-ones, HI<=a (raw dividend, no sign-fix).
//    stall is high only in the accept cycle.
//  Overflow (signed 0x80000000 / -1): quotient 0x80000000, remainder 0.
//    No trap is raised.
//  flush=1 in any state: next state is IDLE.
//    HI/LO are NOT written and done is not asserted.
//    stall drops in the same cycle.
//  flush and start in the same cycle: flush wins; the op is not accepted.
//  hi_o/lo_o show the registers directly, with no bypass.
//    The write is visible the cycle after the writing edge.
// TESTING
//  1. MULT a=0xFFFFFFFE(-2), b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA next cycle; stall never 1.
//  2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//  3. DIV a=-7(0xFFFFFFF9), b=2 -> stall high 33 cycles, done pulse; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  4. DIVU a=100, b=0 -> done in 2nd cycle; LO=0xFFFFFFFF, HI=100; stall high 1 cycle.
//  5. DIVU 1000/7, flush at DIVIDE cycle 10 -> IDLE next edge; HI/LO unchanged; no done; stall=0.
//  6. rst asserted mid-DIVIDE -> immediately IDLE, HI=LO=0; MTHI a=0x1234 afterwards -> HI=0x1234.

Source files
------------

// File: rtl/hilo_muldiv_unit_if.sv
// Bus between the EX stage and the HI/LO multiply/divide unit.
// The pipeline drives the master side and the unit implements the slave side.
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              flush;
  logic [7:0]        alucontrol;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              stall;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start, flush, alucontrol, a, b,
    input  stall, busy, done, hi_o, lo_o
  );

  modport slave (
    input  start, flush, alucontrol, a, b,
    output stall, busy, done, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with a single-cycle multiplier and a radix-2 restoring divider.
// MULT/MULTU/MTHI/MTLO write on the accepting edge; DIV/DIVU stall the pipeline until done.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  hilo_muldiv_unit_if.slave bus
);
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam int CNT_W = $clog2(DATA_W);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;

  logic                accept, is_div, is_signed_div, a_neg, b_neg;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W+1:0]   diff;

  assign accept        = bus.start & ~bus.flush & (state_q == IDLE);
  assign is_signed_div = (bus.alucontrol == EXE_DIV_OP);
  assign is_div        = is_signed_div | (bus.alucontrol == EXE_DIVU_OP);
  assign a_neg         = is_signed_div & bus.a[DATA_W-1];
  assign b_neg         = is_signed_div & bus.b[DATA_W-1];
  assign a_abs         = a_neg ? -bus.a : bus.a;
  assign b_abs         = b_neg ? -bus.b : bus.b;

  // Sign-extend to full width so a plain wide multiply yields the signed product.
  assign prod_s = {{DATA_W{bus.a[DATA_W-1]}}, bus.a} * {{DATA_W{bus.b[DATA_W-1]}}, bus.b};
  assign prod_u = {{DATA_W{1'b0}}, bus.a} * {{DATA_W{1'b0}}, bus.b};

  // The shifted partial remainder needs one extra bit; diff carries a borrow bit on top.
  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvsr_q};

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    count_d   = count_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.alucontrol)
            EXE_MULT_OP:  {hi_d, lo_d} = prod_s;
            EXE_MULTU_OP: {hi_d, lo_d} = prod_u;
            EXE_MTHI_OP:  hi_d = bus.a;
            EXE_MTLO_OP:  lo_d = bus.a;
            EXE_DIV_OP, EXE_DIVU_OP: begin
              quo_neg_d = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              count_d   = '0;
              if (bus.b == '0) begin
                div0_d  = 1'b1;
                rem_d   = bus.a;
                state_d = FINISH;
              end else begin
                div0_d  = 1'b0;
                quo_d   = a_abs;
                rem_d   = '0;
                dvsr_d  = b_abs;
                state_d = DIVIDE;
              end
            end
            default: ;
          endcase
        end
      end
      DIVIDE: begin
        quo_d   = {quo_q[DATA_W-2:0], ~diff[DATA_W+1]};
        rem_d   = diff[DATA_W+1] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(DATA_W-1)) state_d = FINISH;
      end
      FINISH: begin
        // Divide-by-zero hands back the raw dividend in HI, skipping the sign fix.
        if (div0_q) begin
          lo_d = '1;
          hi_d = rem_q;
        end else begin
          lo_d = quo_neg_q ? -quo_q : quo_q;
          hi_d = rem_neg_q ? -rem_q : rem_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      count_q   <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      count_q   <= count_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.stall = (accept & is_div) | ((state_q == DIVIDE) & ~bus.flush);
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == FINISH) & ~bus.flush;
  assign bus.hi_o  = hi_q;
  assign bus.lo_o  = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: multiply, move-to, divide (signed, unsigned,
// by zero, overflow), flush and asynchronous reset, checked against hand-computed values.
module tb_hilo_muldiv_unit;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   stall_n;
  int   done_n;
  int   done_cyc;

  hilo_muldiv_unit_if #(.DATA_W(32)) bus ();

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called one time unit after a posedge; returns with the unit idle again (or the bound spent).
  task automatic apply_stimulus(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv,
                                output int s_n, output int d_n, output int d_cyc);
    bus.start      = 1'b1;
    bus.alucontrol = op;
    bus.a          = av;
    bus.b          = bv;
    s_n   = 0;
    d_n   = 0;
    d_cyc = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (bus.stall) s_n++;
      if (bus.done) begin
        d_n++;
        d_cyc = cyc;
      end
      if (cyc > 0 && !bus.busy) break;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.flush      = 1'b0;
    bus.alucontrol = 8'h00;
    bus.a          = '0;
    bus.b          = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_hi", bus.hi_o, 0);
    check_output("rst_lo", bus.lo_o, 0);
    check_output("rst_stall", bus.stall, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_done", bus.done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    apply_stimulus(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, stall_n, done_n, done_cyc);
    check_output("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
    check_output("mult_lo", bus.lo_o, 32'hFFFF_FFFA);
    check_output("mult_stall", stall_n, 0);

    apply_stimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stall_n, done_n, done_cyc);
    check_output("multu_hi", bus.hi_o, 32'hFFFF_FFFE);
    check_output("multu_lo", bus.lo_o, 32'h0000_0001);

    apply_stimulus(OP_MTLO, 32'h0000_0055, 32'h0, stall_n, done_n, done_cyc);
    check_output("mtlo_lo", bus.lo_o, 32'h0000_0055);
    check_output("mtlo_hi", bus.hi_o, 32'hFFFF_FFFE);
    apply_stimulus(OP_MTHI, 32'h0000_ABCD, 32'h0, stall_n, done_n, done_cyc);
    check_output("mthi_hi", bus.hi_o, 32'h0000_ABCD);
    apply_stimulus(OP_MFHI, 32'h0000_9999, 32'h1, stall_n, done_n, done_cyc);
    check_output("mfhi_hi", bus.hi_o, 32'h0000_ABCD);
    check_output("mfhi_lo", bus.lo_o, 32'h0000_0055);

    bus.flush = 1'b1;
    apply_stimulus(OP_MTLO, 32'h0000_0077, 32'h0, stall_n, done_n, done_cyc);
    bus.flush = 1'b0;
    check_output("flush_start_lo", bus.lo_o, 32'h0000_0055);

    apply_stimulus(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, stall_n, done_n, done_cyc);
    check_output("div_stall_cycles", stall_n, 33);
    check_output("div_done_count", done_n, 1);
    check_output("div_done_cycle", done_cyc, 33);
    check_output("div_idle", bus.busy, 0);
    check_output("div_lo", bus.lo_o, 32'hFFFF_FFFD);
    check_output("div_hi", bus.hi_o, 32'hFFFF_FFFF);

    apply_stimulus(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, stall_n, done_n, done_cyc);
    check_output("div_negb_lo", bus.lo_o, 32'hFFFF_FFFD);
    check_output("div_negb_hi", bus.hi_o, 32'h0000_0001);

    apply_stimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, stall_n, done_n, done_cyc);
    check_output("div_ovf_lo", bus.lo_o, 32'h8000_0000);
    check_output("div_ovf_hi", bus.hi_o, 32'h0000_0000);

    apply_stimulus(OP_DIVU, 32'd100, 32'd0, stall_n, done_n, done_cyc);
    check_output("div0_stall_cycles", stall_n, 1);
    check_output("div0_done_cycle", done_cyc, 1);
    check_output("div0_lo", bus.lo_o, 32'hFFFF_FFFF);
    check_output("div0_hi", bus.hi_o, 32'd100);

    apply_stimulus(OP_DIVU, 32'd1000, 32'd7, stall_n, done_n, done_cyc);
    check_output("divu_stall_cycles", stall_n, 33);
    check_output("divu_lo", bus.lo_o, 32'd142);
    check_output("divu_hi", bus.hi_o, 32'd6);

    apply_stimulus(OP_DIV, 32'hFFFF_FFF7, 32'd0, stall_n, done_n, done_cyc);
    check_output("sdiv0_lo", bus.lo_o, 32'hFFFF_FFFF);
    check_output("sdiv0_hi", bus.hi_o, 32'hFFFF_FFF7);

    // Flush in DIVIDE cycle 10; an MTHI offered mid-divide must be ignored.
    bus.start      = 1'b1;
    bus.alucontrol = OP_DIVU;
    bus.a          = 32'd1000;
    bus.b          = 32'd7;
    #1;
    check_output("flush_accept_stall", bus.stall, 1);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk);
      #1;
      bus.start      = (cyc == 5);
      bus.alucontrol = (cyc == 5) ? OP_MTHI : OP_DIVU;
      bus.a          = (cyc == 5) ? 32'h0000_DEAD : 32'd1000;
    end
    bus.flush = 1'b1;
    #1;
    check_output("flush_stall_drop", bus.stall, 0);
    check_output("flush_no_done", bus.done, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    #1;
    check_output("flush_idle", bus.busy, 0);
    check_output("flush_stall_after", bus.stall, 0);
    check_output("flush_hi", bus.hi_o, 32'hFFFF_FFF7);
    check_output("flush_lo", bus.lo_o, 32'hFFFF_FFFF);

    bus.start      = 1'b1;
    bus.alucontrol = OP_DIVU;
    bus.a          = 32'd1000;
    bus.b          = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_output("arst_busy", bus.busy, 0);
    check_output("arst_stall", bus.stall, 0);
    check_output("arst_hi", bus.hi_o, 0);
    check_output("arst_lo", bus.lo_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(OP_MTHI, 32'h0000_1234, 32'h0, stall_n, done_n, done_cyc);
    check_output("arst_mthi_hi", bus.hi_o, 32'h0000_1234);
    check_output("arst_mthi_lo", bus.lo_o, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
